// File: rtl/auth_tx.sv
// auth_tx: 8N1 UART sender for auth commands 'g'/'s'. Start bit one cycle after request, 10*BAUD_DIV cycles per frame.
// No backpressure: requests during a frame park in a one-deep slot (newest wins, stop beats go). AUTH_TX_HEARTBEAT_EN adds 'g' resends.
module auth_tx #(
  parameter int BAUD_DIV = 2604
`ifdef AUTH_TX_HEARTBEAT_EN
  , parameter int HB_PERIOD = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_go,
  input  logic       send_stop,
  output logic       TX,
  output logic       busy,
  output logic       done,
  output logic [7:0] last_cmd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_PRE  = 12'(BAUD_DIV - 2);
  localparam logic [7:0]  CMD_GO    = 8'h67;
  localparam logic [7:0]  CMD_STOP  = 8'h73;

  state_t      state;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [9:0]  shreg;
  logic [7:0]  cur_byte;
  logic        pend_vld;
  logic [7:0]  pend_byte;

  logic       ext_req;
  logic       hb_fire;
  logic       req_vld;
  logic [7:0] req_byte;
  logic       bit_end;
  logic       done_next;
  logic       next_vld;
  logic [7:0] next_byte;

  assign ext_req   = send_go | send_stop;
  assign req_vld   = ext_req | hb_fire;
  assign req_byte  = send_stop ? CMD_STOP : CMD_GO;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign done_next = (state == STOP) && (baud_cnt == BAUD_PRE);
  assign next_vld  = req_vld | pend_vld;
  assign next_byte = req_vld ? req_byte : pend_byte;

  // Serial line comes straight off a flop so it never glitches.
  assign TX = shreg[0];

`ifdef AUTH_TX_HEARTBEAT_EN
  localparam logic [22:0] HB_LAST = 23'(HB_PERIOD - 1);

  logic        armed;
  logic [22:0] hb_cnt;

  assign hb_fire = armed && (state == IDLE) && (hb_cnt == HB_LAST) && !ext_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed  <= 1'b0;
      hb_cnt <= '0;
    end else if (done_next) begin
      armed  <= (cur_byte == CMD_GO);
      hb_cnt <= '0;
    end else if (armed) begin
      hb_cnt <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + 23'd1;
    end
  end
`else
  assign hb_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
      cur_byte  <= '0;
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      last_cmd  <= '0;
    end else begin
      done <= done_next;
      if (done_next) begin
        last_cmd <= cur_byte;
      end

      if (state == IDLE) begin
        if (req_vld) begin
          state    <= START;
          shreg    <= {1'b1, req_byte, 1'b0};
          cur_byte <= req_byte;
          baud_cnt <= '0;
          busy     <= 1'b1;
        end
      end else begin
        if (req_vld) begin
          pend_vld  <= 1'b1;
          pend_byte <= req_byte;
        end
        baud_cnt <= bit_end ? '0 : baud_cnt + 12'd1;
        if (bit_end) begin
          shreg <= {1'b1, shreg[9:1]};
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
            end
            DATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
            end
            default: begin
              // End of stop bit: chain the next frame with no idle gap.
              if (next_vld) begin
                state    <= START;
                shreg    <= {1'b1, next_byte, 1'b0};
                cur_byte <= next_byte;
                pend_vld <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/auth_tx.md
Name: auth_tx

Overview:
UART transmit side of the rider authentication link; the phone/BLE-side emulator.
- Serializes the power-up command 'g' (8'h67) and the stop command 's' (8'h73) as 8N1 frames on TX.
- The receive side decodes these frames into pwr_up.
- Used as the stimulus source in system-level sims and as the command generator on the BLE bridge board.

Parameters:
BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud); legal range 2..4095, 12-bit baud counter.
HB_PERIOD, 5000000, clk cycles between heartbeat 'g' resends; used only when AUTH_TX_HEARTBEAT_EN is defined.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
send_go  input  1  one-cycle request to transmit 8'h67
send_stop  input  1  one-cycle request to transmit 8'h73
TX  output  1  UART serial out, idles high
busy  output  1  high while a frame is on the wire
done  output  1  one-cycle pulse on the last cycle of a stop bit
last_cmd  output  8  byte of the most recently completed frame

Behaviour:
- Reset (rst high at a clk edge) forces the following on the next edge, including mid-frame with no completion of the current frame:
  - TX=1, busy=0, done=0, last_cmd=8'h00
  - pending slot cleared, FSM to IDLE, all counters 0
- FSM states:
  - IDLE: TX=1.
  - START: TX=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each; 3-bit bit counter.
  - STOP: TX=1 for BAUD_DIV cycles.
- Request arbitration:
  - Requests are sampled every cycle.
  - If send_go and send_stop are both high in one cycle, stop wins and go is dropped.
- Latency from IDLE:
  - A request sampled at edge N makes TX=0 and busy=1 from cycle N+1.
  - The frame lasts exactly 10*BAUD_DIV cycles.
  - done=1 and last_cmd updates on the final STOP cycle.
  - busy falls on the cycle after done.
- Request while busy:
  - The request is stored in a one-deep pending slot. A later request overwrites it, with the same stop-wins rule.
  - The pending frame starts back-to-back: its start bit begins the cycle after done, and busy stays high.
  - The pending slot clears when its frame begins.
- Request in the same cycle as done is accepted as pending and starts back-to-back.
- Shift register is 10 bits {1, data[7:0], 0}, loaded on the START entry cycle and shifted right at each bit boundary. TX is driven from the register LSB, registered and glitch-free.
- Baud counter counts 0..BAUD_DIV-1 and wraps; a bit boundary occurs at the wrap.
- Requests are never lost except by an overwrite in the pending slot or by reset.

Optional Feature:
Macro AUTH_TX_HEARTBEAT_EN.
- Defined:
  - A 23-bit heartbeat counter runs while "armed". Armed is set when a 'g' frame completes and cleared when an 's' frame completes or on reset.
  - When armed, the FSM is IDLE and the counter reaches HB_PERIOD-1, the block self-issues send_go and restarts the counter.
  - Any completed frame restarts the counter.
  - An external request in the same cycle takes priority over the heartbeat.
- Not defined: no counter and no armed state; frames are sent only on explicit requests.

Test Plan:
- BAUD_DIV=4, reset, then 1-cycle send_go -> TX low cycles 1-4; bits 1,1,1,0,0,1,1,0 in 4-cycle groups; high cycles 37-40; done on cycle 40; last_cmd=8'h67; busy low on cycle 41.
- send_go and send_stop high in the same cycle -> exactly one frame of 8'h73; last_cmd=8'h73.
- send_go, then send_go at cycle 10, then send_stop at cycle 20 -> two back-to-back frames ('g' then 's'), no idle gap, busy continuous for 80 cycles.
- rst asserted at cycle 15 of a frame -> next cycle TX=1, busy=0, no done pulse; a later send_go produces a clean frame.
- Request on the done cycle -> second start bit on the cycle immediately after done.
- With AUTH_TX_HEARTBEAT_EN, HB_PERIOD=100, BAUD_DIV=4:
  - after a 'g' frame, an automatic 'g' starts 100 cycles after done;
  - after an 's' frame, no further frames over 500 cycles.
